// File: rtl/menu_pkg.sv
// Shared types, default colours and geometry helper for the configurable
// menu overlay / selection controller.
package menu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LOCKED  = 2'd2
  } menu_state_e;

  localparam logic [11:0] DEF_BORDER_RGB = 12'hFFF;
  localparam logic [11:0] DEF_HOVER_RGB  = 12'h0A0;
  localparam logic [11:0] DEF_PRESS_RGB  = 12'hA00;

  // Items are stacked with a fixed pitch of height plus gap.
  function automatic logic [11:0] item_top_y(input int k, input int y0, input int h, input int gap);
    return 12'(y0 + k * (h + gap));
  endfunction

endpackage

// File: rtl/menu_item_hit.sv
// Combinational hit test of one (x,y) point against every menu item:
// per-item inside flags and per-item border flags (border implies inside).
module menu_item_hit
  import menu_pkg::*;
#(
  parameter int N_ITEMS  = 3,
  parameter int ITEM_X   = 312,
  parameter int ITEM_W   = 400,
  parameter int ITEM_Y0  = 200,
  parameter int ITEM_H   = 80,
  parameter int ITEM_GAP = 40,
  parameter int BORDER_W = 4
) (
  input  logic [11:0]        x_i,
  input  logic [11:0]        y_i,
  output logic [N_ITEMS-1:0] inside_o,
  output logic [N_ITEMS-1:0] border_o
);

  localparam logic [11:0] X_LO = 12'(ITEM_X);
  localparam logic [11:0] X_HI = 12'(ITEM_X + ITEM_W);
  localparam logic [11:0] X_BL = 12'(ITEM_X + BORDER_W);
  localparam logic [11:0] X_BR = 12'(ITEM_X + ITEM_W - BORDER_W);

  for (genvar k = 0; k < N_ITEMS; k++) begin : g_item
    localparam logic [11:0] Y_LO = item_top_y(k, ITEM_Y0, ITEM_H, ITEM_GAP);
    localparam logic [11:0] Y_HI = Y_LO + 12'(ITEM_H);
    localparam logic [11:0] Y_BT = Y_LO + 12'(BORDER_W);
    localparam logic [11:0] Y_BB = Y_HI - 12'(BORDER_W);

    logic in_x_s;
    logic in_y_s;
    logic edge_s;

    // Half-open intervals: start inclusive, end exclusive.
    assign in_x_s      = (x_i >= X_LO) && (x_i < X_HI);
    assign in_y_s      = (y_i >= Y_LO) && (y_i < Y_HI);
    assign edge_s      = (x_i < X_BL) || (x_i >= X_BR) || (y_i < Y_BT) || (y_i >= Y_BB);
    assign inside_o[k] = in_x_s && in_y_s;
    assign border_o[k] = in_x_s && in_y_s && edge_s;
  end

endmodule

// File: rtl/menu_select_ctl.sv
// N-item menu overlay with a two-stage pixel pipeline and a mouse-click
// selection FSM producing a one-cycle select pulse with the chosen index.
module menu_select_ctl
  import menu_pkg::*;
#(
  parameter int          N_ITEMS    = 3,
  parameter int          IDX_W      = 2,
  parameter int          ITEM_X     = 312,
  parameter int          ITEM_W     = 400,
  parameter int          ITEM_Y0    = 200,
  parameter int          ITEM_H     = 80,
  parameter int          ITEM_GAP   = 40,
  parameter int          BORDER_W   = 4,
  parameter logic [11:0] BORDER_RGB = DEF_BORDER_RGB,
  parameter logic [11:0] HOVER_RGB  = DEF_HOVER_RGB,
  parameter logic [11:0] PRESS_RGB  = DEF_PRESS_RGB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      vcount_in,
  input  logic [10:0]      hcount_in,
  input  logic             vsync_in,
  input  logic             hsync_in,
  input  logic             vblnk_in,
  input  logic             hblnk_in,
  input  logic [11:0]      rgb_in,
  input  logic [11:0]      xpos,
  input  logic [11:0]      ypos,
  input  logic             mouse_left,
  input  logic             menu_reopen,
  output logic [10:0]      vcount_out,
  output logic [10:0]      hcount_out,
  output logic             vsync_out,
  output logic             hsync_out,
  output logic             vblnk_out,
  output logic             hblnk_out,
  output logic [11:0]      rgb_out,
  output logic             select_valid,
  output logic [IDX_W-1:0] select_idx,
  output logic             menu_active
);

  function automatic logic [IDX_W-1:0] first_idx(input logic [N_ITEMS-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = N_ITEMS - 1; k >= 0; k--) begin
      if (vec[k]) begin
        idx = IDX_W'(k);
      end
    end
    return idx;
  endfunction

  logic [N_ITEMS-1:0] px_inside_s, px_border_s;
  logic [N_ITEMS-1:0] ptr_inside_s, ptr_border_s, ptr_vec_s;
  logic               ptr_hit_s;
  logic [IDX_W-1:0]   ptr_idx_s;

  logic [11:0]        ptr_x_q, ptr_y_q;
  logic               mouse_prev_q, vblnk_prev_q;
  logic               press_s, release_s;

  menu_state_e        state_q, state_d;
  logic [IDX_W-1:0]   press_idx_q, press_idx_d;
  logic               sel_valid_q, sel_valid_d;
  logic [IDX_W-1:0]   sel_idx_q, sel_idx_d;
  logic               active_q;
  logic               hover_valid_q, hover_valid_d;
  logic [IDX_W-1:0]   hover_idx_q, hover_idx_d;

  logic [10:0]        vc1_q, hc1_q, vc2_q, hc2_q;
  logic               vs1_q, hs1_q, vb1_q, hb1_q;
  logic               vs2_q, hs2_q, vb2_q, hb2_q;
  logic [11:0]        rgb1_q, rgb2_q, colour_d;
  logic               px_hit1_q, px_border1_q;
  logic [IDX_W-1:0]   px_idx1_q;

  menu_item_hit #(
    .N_ITEMS(N_ITEMS), .ITEM_X(ITEM_X), .ITEM_W(ITEM_W), .ITEM_Y0(ITEM_Y0),
    .ITEM_H(ITEM_H), .ITEM_GAP(ITEM_GAP), .BORDER_W(BORDER_W)
  ) u_px_hit (
    .x_i      ({1'b0, hcount_in}),
    .y_i      ({1'b0, vcount_in}),
    .inside_o (px_inside_s),
    .border_o (px_border_s)
  );

  menu_item_hit #(
    .N_ITEMS(N_ITEMS), .ITEM_X(ITEM_X), .ITEM_W(ITEM_W), .ITEM_Y0(ITEM_Y0),
    .ITEM_H(ITEM_H), .ITEM_GAP(ITEM_GAP), .BORDER_W(BORDER_W)
  ) u_ptr_hit (
    .x_i      (ptr_x_q),
    .y_i      (ptr_y_q),
    .inside_o (ptr_inside_s),
    .border_o (ptr_border_s)
  );

  // Border cells are inside cells too, so the union is the pointer hit set.
  assign ptr_vec_s = ptr_inside_s | ptr_border_s;
  assign ptr_hit_s = |ptr_vec_s;
  assign ptr_idx_s = first_idx(ptr_vec_s);
  assign press_s   = mouse_left & ~mouse_prev_q;
  assign release_s = ~mouse_left & mouse_prev_q;

  // Pointer/button sampling and frame-hover edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_x_q      <= 12'd0;
      ptr_y_q      <= 12'd0;
      mouse_prev_q <= 1'b0;
      vblnk_prev_q <= 1'b0;
    end else begin
      ptr_x_q      <= xpos;
      ptr_y_q      <= ypos;
      mouse_prev_q <= mouse_left;
      vblnk_prev_q <= vblnk_in;
    end
  end

  // Selection FSM next state plus hover latch.
  always_comb begin
    state_d       = state_q;
    press_idx_d   = press_idx_q;
    sel_valid_d   = 1'b0;
    sel_idx_d     = sel_idx_q;
    hover_valid_d = hover_valid_q;
    hover_idx_d   = hover_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (press_s && ptr_hit_s) begin
          state_d     = ST_PRESSED;
          press_idx_d = ptr_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESSED: begin
        if (release_s && ptr_hit_s && (ptr_idx_s == press_idx_q)) begin
          state_d     = ST_LOCKED;
          sel_valid_d = 1'b1;
          sel_idx_d   = press_idx_q;
        end else if (release_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PRESSED;
        end
      end
      ST_LOCKED: begin
        // A press coinciding with reopen is dropped: IDLE only reacts next cycle.
        if (menu_reopen) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (vblnk_in && !vblnk_prev_q) begin
      hover_valid_d = ptr_hit_s;
      hover_idx_d   = ptr_idx_s;
    end else begin
      hover_valid_d = hover_valid_q;
    end
  end

  // FSM, selection outputs and hover registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      press_idx_q   <= '0;
      sel_valid_q   <= 1'b0;
      sel_idx_q     <= '0;
      active_q      <= 1'b0;
      hover_valid_q <= 1'b0;
      hover_idx_q   <= '0;
    end else begin
      state_q       <= state_d;
      press_idx_q   <= press_idx_d;
      sel_valid_q   <= sel_valid_d;
      sel_idx_q     <= sel_idx_d;
      active_q      <= (state_q != ST_LOCKED);
      hover_valid_q <= hover_valid_d;
      hover_idx_q   <= hover_idx_d;
    end
  end

  // Pipeline stage 1: timing, background and pixel hit flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vc1_q        <= 11'd0;
      hc1_q        <= 11'd0;
      vs1_q        <= 1'b0;
      hs1_q        <= 1'b0;
      vb1_q        <= 1'b0;
      hb1_q        <= 1'b0;
      rgb1_q       <= 12'd0;
      px_hit1_q    <= 1'b0;
      px_idx1_q    <= '0;
      px_border1_q <= 1'b0;
    end else begin
      vc1_q        <= vcount_in;
      hc1_q        <= hcount_in;
      vs1_q        <= vsync_in;
      hs1_q        <= hsync_in;
      vb1_q        <= vblnk_in;
      hb1_q        <= hblnk_in;
      rgb1_q       <= rgb_in;
      px_hit1_q    <= |px_inside_s;
      px_idx1_q    <= first_idx(px_inside_s);
      px_border1_q <= |px_border_s;
    end
  end

  // Colour priority: blank, locked passthrough, border, press, hover, background.
  always_comb begin
    colour_d = rgb1_q;
    if (vb1_q || hb1_q) begin
      colour_d = 12'h000;
    end else if (!active_q) begin
      colour_d = rgb1_q;
    end else if (px_border1_q) begin
      colour_d = BORDER_RGB;
    end else if (px_hit1_q && (state_q == ST_PRESSED) && (px_idx1_q == press_idx_q)) begin
      colour_d = PRESS_RGB;
    end else if (px_hit1_q && hover_valid_q && (px_idx1_q == hover_idx_q)) begin
      colour_d = HOVER_RGB;
    end else begin
      colour_d = rgb1_q;
    end
  end

  // Pipeline stage 2: output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vc2_q  <= 11'd0;
      hc2_q  <= 11'd0;
      vs2_q  <= 1'b0;
      hs2_q  <= 1'b0;
      vb2_q  <= 1'b0;
      hb2_q  <= 1'b0;
      rgb2_q <= 12'd0;
    end else begin
      vc2_q  <= vc1_q;
      hc2_q  <= hc1_q;
      vs2_q  <= vs1_q;
      hs2_q  <= hs1_q;
      vb2_q  <= vb1_q;
      hb2_q  <= hb1_q;
      rgb2_q <= colour_d;
    end
  end

  assign vcount_out   = vc2_q;
  assign hcount_out   = hc2_q;
  assign vsync_out    = vs2_q;
  assign hsync_out    = hs2_q;
  assign vblnk_out    = vb2_q;
  assign hblnk_out    = hb2_q;
  assign rgb_out      = rgb2_q;
  assign select_valid = sel_valid_q;
  assign select_idx   = sel_idx_q;
  assign menu_active  = active_q;

endmodule

// File: tb/tb_menu_select_ctl.sv
// Scoreboard bench for menu_select_ctl: a behavioural menu model predicts
// pixels and selection status; a negedge monitor pops and compares.
module tb_menu_select_ctl;

  localparam int IX = 312, IW = 400, IY0 = 200, IH = 80, IGAP = 40, BW = 4, NI = 3;
  localparam logic [11:0] C_BORDER = 12'hFFF;
  localparam logic [11:0] C_HOVER  = 12'h0A0;
  localparam logic [11:0] C_PRESS  = 12'hA00;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] vcount_in, hcount_in, vcount_out, hcount_out;
  logic        vsync_in, hsync_in, vblnk_in, hblnk_in;
  logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
  logic [11:0] rgb_in, rgb_out, xpos, ypos;
  logic        mouse_left, menu_reopen, select_valid, menu_active;
  logic [1:0]  select_idx;

  menu_select_ctl dut (
    .clk(clk), .rst(rst),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .mouse_left(mouse_left), .menu_reopen(menu_reopen),
    .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .hsync_out(hsync_out), .vblnk_out(vblnk_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out), .select_valid(select_valid), .select_idx(select_idx),
    .menu_active(menu_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } pix_t;

  typedef struct {
    int         due;
    logic       sv;
    logic [1:0] si;
    logic       act;
  } st_t;

  pix_t pix_q[$];
  st_t  st_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Model state: 0 idle, 1 pressed, 2 locked; values are "after the last edge".
  int m_st, m_pidx, m_sidx, m_hidx, m_px, m_py;
  bit m_act, m_hv, m_pm, m_pvb;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int top_of(int k);
    return IY0 + k * (IH + IGAP);
  endfunction

  function automatic int item_at(int x, int y);
    for (int k = 0; k < NI; k++) begin
      if (x >= IX && x < IX + IW && y >= top_of(k) && y < top_of(k) + IH) return k;
    end
    return -1;
  endfunction

  function automatic bit on_border(int x, int y, int k);
    return (x < IX + BW) || (x >= IX + IW - BW) || (y < top_of(k) + BW) || (y >= top_of(k) + IH - BW);
  endfunction

  function automatic logic [11:0] exp_colour(int x, int y, logic [11:0] bg, bit blank);
    int k;
    k = item_at(x, y);
    if (blank) return 12'h000;
    if (!m_act) return bg;
    if (k >= 0 && on_border(x, y, k)) return C_BORDER;
    if (k >= 0 && m_st == 1 && k == m_pidx) return C_PRESS;
    if (k >= 0 && m_hv && k == m_hidx) return C_HOVER;
    return bg;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pidx = 0; m_sidx = 0; m_hidx = 0; m_px = 0; m_py = 0;
    m_act = 1'b0; m_hv = 1'b0; m_pm = 1'b0; m_pvb = 1'b0;
  endtask

  // Predict the effect of the next clock edge on the currently driven inputs.
  task automatic step();
    int   c, live;
    bit   press, rel, sel;
    pix_t p;
    st_t  s;
    c     = cyc + 1;
    live  = item_at(m_px, m_py);
    press = mouse_left && !m_pm;
    rel   = !mouse_left && m_pm;
    sel   = 1'b0;
    m_act = (m_st != 2);
    if (m_st == 0) begin
      if (press && live >= 0) begin m_st = 1; m_pidx = live; end
    end else if (m_st == 1) begin
      if (rel && live == m_pidx) begin sel = 1'b1; m_sidx = m_pidx; m_st = 2; end
      else if (rel) m_st = 0;
    end else begin
      if (menu_reopen) m_st = 0;
    end
    if (vblnk_in && !m_pvb) begin m_hv = (live >= 0); m_hidx = live; end
    m_pm = mouse_left; m_px = int'(xpos); m_py = int'(ypos); m_pvb = vblnk_in;
    s.due = c; s.sv = sel; s.si = 2'(m_sidx); s.act = m_act;
    st_q.push_back(s);
    p.due = c + 1; p.h = hcount_in; p.v = vcount_in; p.hs = hsync_in; p.vs = vsync_in;
    p.hb = hblnk_in; p.vb = vblnk_in;
    p.rgb = exp_colour(int'(hcount_in), int'(vcount_in), rgb_in, hblnk_in | vblnk_in);
    pix_q.push_back(p);
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input int h, input int v, input logic [11:0] rgb);
    hcount_in = 11'(h); vcount_in = 11'(v); rgb_in = rgb;
  endtask

  task automatic set_ptr(input int x, input int y);
    xpos = 12'(x); ypos = 12'(y);
  endtask

  // Monitor: compare every scoreboard entry on the cycle its output is due.
  always @(negedge clk) begin
    automatic pix_t mp;
    automatic st_t  ms;
    if (!rst) begin
      while (st_q.size() > 0 && st_q[0].due <= cyc) begin
        ms = st_q.pop_front();
        if (ms.due < cyc) check("status_stale", 32'(cyc), 32'(ms.due));
        else begin
          check("select_valid", 32'(select_valid), 32'(ms.sv));
          check("select_idx", 32'(select_idx), 32'(ms.si));
          check("menu_active", 32'(menu_active), 32'(ms.act));
        end
      end
      while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
        mp = pix_q.pop_front();
        if (mp.due < cyc) check("pixel_stale", 32'(cyc), 32'(mp.due));
        else begin
          check("rgb_out", 32'(rgb_out), 32'(mp.rgb));
          check("hcount_out", 32'(hcount_out), 32'(mp.h));
          check("vcount_out", 32'(vcount_out), 32'(mp.v));
          check("syncs", {30'd0, hsync_out, vsync_out}, {30'd0, mp.hs, mp.vs});
          check("blanks", {30'd0, hblnk_out, vblnk_out}, {30'd0, mp.hb, mp.vb});
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_rgb"}, 32'(rgb_out), 32'd0);
    check({tag, "_counts"}, {10'd0, hcount_out, vcount_out}, 32'd0);
    check({tag, "_strobes"}, {28'd0, hsync_out, vsync_out, hblnk_out, vblnk_out}, 32'd0);
    check({tag, "_select"}, {29'd0, select_valid, select_idx}, 32'd0);
    check({tag, "_menu_active"}, 32'(menu_active), 32'd0);
  endtask

  task automatic click(input int x, input int y, input int hold);
    set_ptr(x, y); repeat (2) step();
    mouse_left = 1'b1; repeat (hold) step();
    mouse_left = 1'b0; repeat (3) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int hl[8];
    int vl[8];
    hl = '{311, 312, 315, 316, 707, 708, 711, 712};
    vl = '{199, 200, 204, 276, 279, 280, 320, 519};
    rst = 1'b1; model_reset();
    set_px(0, 0, 12'h000); set_ptr(0, 0);
    vsync_in = 1'b0; hsync_in = 1'b0; vblnk_in = 1'b0; hblnk_in = 1'b0;
    mouse_left = 1'b0; menu_reopen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Passthrough with the pointer outside all items.
    set_px(100, 50, 12'h123); hsync_in = 1'b1;
    repeat (6) step();
    hsync_in = 1'b0;

    // Hover latch on a vblnk rise, then hover / plain / border pixels.
    set_ptr(500, 240); repeat (3) step();
    vblnk_in = 1'b1; repeat (2) step();
    vblnk_in = 1'b0;
    set_px(500, 240, 12'h456); step();
    set_px(500, 350, 12'h456); step();
    set_px(312, 240, 12'h456); step();
    set_px(711, 279, 12'h456); step();
    set_px(316, 244, 12'h456); step();
    set_px(712, 240, 12'h456); step();

    // Click item 1; pressed highlight while held.
    set_px(500, 370, 12'h789);
    click(500, 370, 10);

    // Locked: clicks ignored, background passes through.
    set_px(500, 240, 12'h321);
    click(500, 240, 3);
    menu_reopen = 1'b1; step(); menu_reopen = 1'b0; repeat (2) step();

    // Abort: press item 2, move away, release; then select item 0.
    set_ptr(500, 480); repeat (2) step();
    mouse_left = 1'b1; repeat (3) step();
    set_ptr(100, 100); repeat (3) step();
    mouse_left = 1'b0; repeat (3) step();
    click(500, 240, 4);

    // Reopen and press in the same locked cycle: press discarded.
    mouse_left = 1'b1; menu_reopen = 1'b1; step();
    menu_reopen = 1'b0; repeat (5) step();
    mouse_left = 1'b0; repeat (3) step();

    // Async reset while PRESSED, button released during reset.
    set_ptr(500, 370); repeat (2) step();
    mouse_left = 1'b1; repeat (3) step();
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    pix_q.delete(); st_q.delete(); model_reset();
    mouse_left = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) step();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      set_px($urandom_range(250, 760), $urandom_range(150, 580), 12'($urandom));
      if ($urandom_range(0, 3) == 0) hcount_in = 11'(hl[$urandom_range(0, 7)]);
      if ($urandom_range(0, 3) == 0) vcount_in = 11'(vl[$urandom_range(0, 7)]);
      hsync_in = 1'($urandom);
      vsync_in = 1'($urandom);
      hblnk_in = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) vblnk_in = ~vblnk_in;
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 4))
          0: set_ptr(500 + $urandom_range(0, 300) - 150, 240 + $urandom_range(0, 60) - 30);
          1: set_ptr(500 + $urandom_range(0, 300) - 150, 360 + $urandom_range(0, 60) - 30);
          2: set_ptr(500 + $urandom_range(0, 300) - 150, 480 + $urandom_range(0, 60) - 30);
          3: set_ptr(100, 100);
          default: set_ptr($urandom_range(0, 1023), $urandom_range(0, 767));
        endcase
      end
      if ($urandom_range(0, 7) == 0) mouse_left = ~mouse_left;
      menu_reopen = ($urandom_range(0, 29) == 0);
      step();
    end
    menu_reopen = 1'b0; mouse_left = 1'b0;
    repeat (4) step();
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/menu_select_ctl.md
Name: menu_select_ctl

Overview:
- Parametrised menu overlay and selection controller for the PONG VGA pipeline.
- Sits between the menu background generator and the display output. Passes hcount/vcount/sync/blank through a fixed pipeline.
- Paints N_ITEMS rectangular menu buttons with border, hover and press highlights.
- Runs a mouse-click FSM that emits a one-cycle selection pulse with the chosen item index. Replaces the fixed single-screen menu with a configurable N-item menu.

Parameters:
- N_ITEMS, 3: number of vertically stacked items, 1..8.
- IDX_W, 2: index width; 2**IDX_W >= N_ITEMS.
- ITEM_X, 312: left x of every item.
- ITEM_W, 400: item width in pixels.
- ITEM_Y0, 200: top y of item 0.
- ITEM_H, 80: item height.
- ITEM_GAP, 40: vertical gap between items.
- BORDER_W, 4: border thickness, must be < ITEM_H/2 and < ITEM_W/2.
- BORDER_RGB, 12'hFFF: border colour.
- HOVER_RGB, 12'h0A0: interior colour of hovered item.
- PRESS_RGB, 12'hA00: interior colour of pressed item.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- vcount_in, hcount_in  in  11  timing counters
- vsync_in, hsync_in, vblnk_in, hblnk_in  in  1  timing strobes
- rgb_in  in  12  background pixel
- xpos, ypos  in  12  mouse position, synchronous to clk
- mouse_left  in  1  left button level, synchronous to clk
- menu_reopen  in  1  one-cycle pulse returning the menu from LOCKED
- vcount_out, hcount_out  out  11  delayed timing counters
- vsync_out, hsync_out, vblnk_out, hblnk_out  out  1  delayed timing strobes
- rgb_out  out  12  composited pixel
- select_valid  out  1  one-cycle selection pulse
- select_idx  out  IDX_W  chosen item; held until the next selection
- menu_active  out  1  high while the menu is not LOCKED

Behaviour:
- Reset (async, rst=1): all outputs 0; FSM=IDLE, so menu_active=1 one cycle after reset release; frame hover invalid; mouse edge register 0.
- Latency: every timing output and rgb_out is exactly 2 clk after the corresponding input.
  - Stage 1 registers timing and rgb_in and computes per-item hit flags.
  - Stage 2 registers the final colour.
- Item k region: y in [ITEM_Y0+k*(ITEM_H+ITEM_GAP), that value + ITEM_H), x in [ITEM_X, ITEM_X+ITEM_W). Start inclusive, end exclusive. Compare with 12-bit unsigned arithmetic and zero-extend hcount/vcount.
- Border: pixel inside item k and within BORDER_W of any of its edges.
- Colour priority per pixel, from stage-1 delayed blanks:
  1. Either blank delayed -> 0.
  2. menu_active=0 -> rgb_in delayed.
  3. Border -> BORDER_RGB.
  4. Interior of the pressed item (state PRESSED) -> PRESS_RGB.
  5. Interior of the frame-hover item -> HOVER_RGB.
  6. Otherwise -> rgb_in delayed.
- Frame hover latch:
  - On the rising edge of vblnk_in, latch which item contains (xpos,ypos): hover_valid plus hover_idx.
  - Drawing uses only the latched value, so highlights never tear mid-frame.
- Live hit: the FSM uses xpos/ypos registered once (1-cycle). Lowest index wins on overlap, which cannot occur with legal parameters.
- Button edges: press = mouse_left & ~prev; release = ~mouse_left & prev.
- FSM:
  - IDLE: press with live hit on item k -> PRESSED, store k. Press with no hit is ignored.
  - PRESSED: release with live hit on the stored k -> select_valid=1 for that cycle, select_idx<=k, -> LOCKED. Release elsewhere -> IDLE with no pulse. The pointer may leave and re-enter the item while the button is held.
  - LOCKED: menu_active=0; presses ignored; menu_reopen -> IDLE.
  - menu_reopen in IDLE or PRESSED: ignored.
- Simultaneous events:
  - menu_reopen and press in the same LOCKED cycle: go to IDLE and discard that press.
  - Press and release cannot coincide.
- select_valid is registered: it asserts in the cycle after the release is sampled.
- Reset mid-PRESSED: no pulse is emitted; FSM returns to IDLE.

Decomposition:
- Package menu_pkg holds:
  - FSM state encoding (IDLE=2'd0, PRESSED=2'd1, LOCKED=2'd2).
  - The default colour constants.
  - A function returning the item top y for index k.
- One natural sub-module, menu_item_hit: combinational. Given x, y and the geometry parameters, it returns an N_ITEMS-bit inside vector and an N_ITEMS-bit border vector. It is instantiated twice: once for the pixel path, once for the pointer path.

Test Plan:
- Reset/passthrough: rst pulse, then drive hcount=100, vcount=50, rgb_in=12'h123, pointer outside all items. Outputs equal the inputs 2 cycles later; select_valid stays 0.
- Hover latch: place the pointer at (500,240) (item 0), run a vblnk rise. Pixels (500,240) and (500,350) of the next frame give rgb_out=HOVER_RGB and rgb_in respectively. Pixel (312,240) gives BORDER_RGB.
- Click: pointer at (500,370) (item 1), press then release 10 cycles later. select_valid is high for exactly 1 cycle, select_idx=1, and menu_active drops to 0 on the following cycle.
- Abort: press on item 2 at (500,480), move to (100,100), release. No pulse; FSM returns to IDLE. A subsequent click on item 0 selects index 0.
- LOCKED: after a selection, clicks are ignored and rgb_out equals rgb_in. Pulse menu_reopen in the same cycle as a press: menu_active returns to 1 and no PRESSED state is entered.
- Async reset during PRESSED: all outputs are 0 immediately; there is no select pulse after release.
